// File: rtl/nios_onchip_memory_arbiter.sv
// Weighted round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM masters.
// Zero-wait grant when uncontended, fixed 1-cycle read return, out-of-range accesses flagged, never written.
module nios_onchip_memory_arbiter #(
  parameter int DEPTH = 25000,
  parameter int W0    = 1,
  parameter int W1    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] p0_address,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [3:0]  p0_byteenable,
  input  logic [31:0] p0_writedata,
  output logic        p0_waitrequest,
  output logic [31:0] p0_readdata,
  output logic        p0_readdatavalid,
  input  logic [14:0] p1_address,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [3:0]  p1_byteenable,
  input  logic [31:0] p1_writedata,
  output logic        p1_waitrequest,
  output logic [31:0] p1_readdata,
  output logic        p1_readdatavalid,
  output logic [14:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic        err_oor
);

  localparam logic [15:0] DEPTH_L = 16'(DEPTH);
  localparam logic [7:0]  W0_L    = 8'(W0);
  localparam logic [7:0]  W1_L    = 8'(W1);

  logic        r_owner;
  logic [7:0]  r_count;
  logic        r_tag_vld;
  logic        r_tag_port;
  logic        r_tag_oor;
  logic        r_err_oor;

  logic        w_req0;
  logic        w_req1;
  logic        w_grant;
  logic        w_win;
  logic [7:0]  w_owner_weight;
  logic [14:0] w_addr;
  logic        w_win_write;
  logic        w_oor;
  logic [7:0]  w_count_inc;
  logic [31:0] w_rdata;

  assign w_req0         = p0_read | p0_write;
  assign w_req1         = p1_read | p1_write;
  assign w_owner_weight = r_owner ? W1_L : W0_L;

  // Reset suppresses every grant so nothing reaches the RAM while it is held.
  always_comb begin
    w_grant = 1'b0;
    w_win   = r_owner;
    if (!reset) begin
      if (w_req0 && w_req1) begin
        w_grant = 1'b1;
        w_win   = (r_count < w_owner_weight) ? r_owner : ~r_owner;
      end else if (w_req0 || w_req1) begin
        w_grant = 1'b1;
        w_win   = w_req1;
      end
    end
  end

  assign w_addr      = w_win ? p1_address : p0_address;
  assign w_win_write = w_win ? p1_write   : p0_write;
  assign w_oor       = {1'b0, w_addr} >= DEPTH_L;
  assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  assign p0_waitrequest = ~(w_grant & ~w_win);
  assign p1_waitrequest = ~(w_grant &  w_win);

  assign mem_address    = w_addr;
  assign mem_byteenable = w_win ? p1_byteenable : p0_byteenable;
  assign mem_writedata  = w_win ? p1_writedata  : p0_writedata;
  assign mem_chipselect = w_grant;
  assign mem_write      = w_grant & w_win_write & ~w_oor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= 1'b0;
      r_count    <= 8'd0;
      r_tag_vld  <= 1'b0;
      r_tag_port <= 1'b0;
      r_tag_oor  <= 1'b0;
      r_err_oor  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner <= w_win;
        r_count <= (w_win == r_owner) ? w_count_inc : 8'd1;
      end
      r_tag_vld  <= w_grant & ~w_win_write;
      r_tag_port <= w_win;
      r_tag_oor  <= w_oor;
      if (w_grant && w_oor) begin
        r_err_oor <= 1'b1;
      end
    end
  end

  // An out-of-range read still completes, but returns zeros instead of aliased RAM data.
  assign w_rdata          = r_tag_oor ? 32'h0000_0000 : mem_readdata;
  assign p0_readdata      = w_rdata;
  assign p1_readdata      = w_rdata;
  assign p0_readdatavalid = r_tag_vld & ~r_tag_port & ~reset;
  assign p1_readdatavalid = r_tag_vld &  r_tag_port & ~reset;
  assign err_oor          = r_err_oor & ~reset;

endmodule

// File: doc/nios_onchip_memory_arbiter.md
# nios_onchip_memory_arbiter

Two-port Avalon-MM arbiter that shares the single-port 32-bit x 25000-word on-chip RAM between the Nios II data master (port 0) and the VGA scan-out reader (port 1). It sits directly in front of the RAM's s1 slave, grants one transfer per cycle by weighted round-robin, and routes read data back with a fixed one-cycle latency. Out-of-range addresses are caught and flagged, never forwarded as writes.

## Interface
- DEPTH, 25000: number of valid words; addresses >= DEPTH are out of range.
- W0, 1: port 0 weight, consecutive grants allowed under contention (1..255).
- W1, 4: port 1 weight, consecutive grants allowed under contention (1..255).

- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- pN_address  in  15  word address, N = 0, 1.
- pN_read  in  1  read request.
- pN_write  in  1  write request; wins over pN_read if both high.
- pN_byteenable  in  4  byte lanes for writes.
- pN_writedata  in  32  write data.
- pN_waitrequest  out  1  low = request accepted this cycle.
- pN_readdata  out  32  read data, qualified by pN_readdatavalid.
- pN_readdatavalid  out  1  one-cycle pulse with read data.
- mem_address  out  15  to RAM.
- mem_byteenable  out  4  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  32  to RAM.
- mem_readdata  in  32  from RAM, valid the cycle after address sampled.
- err_oor  out  1  sticky flag: an out-of-range access was accepted.

## Operation
- Request: reqN = pN_read | pN_write.
- Registers: owner O (0/1), count C (8 bit), read tag (valid, port, oor), err_oor.
- Winner, combinational, each cycle:
  - no request: no grant; O and C hold.
  - one request: that port wins. If it is O, C = min(C+1, 255). Otherwise O = winner, C = 1.
  - both request: if C < W_O, O wins and C = C+1. Otherwise the other port wins, O = other, C = 1.
- Winner gets pN_waitrequest = 0. The loser and all idle ports get 1.
- Memory side is driven combinationally from the winner:
  - mem_address, mem_byteenable and mem_writedata are copied from the winner.
  - mem_chipselect = granted.
  - mem_write = granted & winner write & address < DEPTH.
  - With no grant, mem_chipselect = 0, mem_write = 0 and the data buses are don't-care.
- Read accept (granted read, no write): tag registers valid = 1, port = winner, oor = (address >= DEPTH). Otherwise the tag valid bit registers 0.
- Read return, in the cycle after acceptance:
  - p[tag.port]_readdatavalid = tag.valid.
  - Both pN_readdata = tag.oor ? 0x00000000 : mem_readdata.
- Out-of-range accepted write: the RAM is not written. The master still sees waitrequest low and completes normally.
- err_oor sets on any accepted out-of-range access and clears only on reset.

## Timing
- Reset values, while reset is high and on the first cycle after it:
  - O = 0, C = 0, tag valid = 0, err_oor = 0.
  - While reset is high: both waitrequests = 1, mem_chipselect = 0, mem_write = 0, both readdatavalid = 0.
- Acceptance is zero-wait when uncontended: waitrequest is low in the same cycle the request appears.
- Read latency is exactly 1 cycle from acceptance edge to readdatavalid. Back-to-back reads give one readdatavalid per cycle, in order.
- Reset mid-operation: a read accepted in the cycle before reset asserts produces no readdatavalid.
- Fairness under continuous contention: the grant pattern repeats with W_O grants to the current owner, then a handoff. With defaults, the steady period is 1 grant to p0 then 4 to p1.
- C saturates at 255 and never wraps, so an uncontended owner keeps its turn indefinitely.

## Test plan
- After reset, p0 writes 0xDEADBEEF to addr 0x0010 with byteenable 0xF, then reads addr 0x0010 -> waitrequest is low both cycles; p0_readdatavalid pulses 1 cycle after the read with 0xDEADBEEF.
- Both ports issue continuous reads from reset with W0=1, W1=4 -> grant sequence p0, p1, p1, p1, p1, p0, p1 ...; each readdatavalid appears on the correct port with that port's data.
- p0 writes byteenable 0x3 data 0x0000ABCD over 0x11110000 at addr 5, then reads addr 5 -> returns 0x1111ABCD.
- p1 write to addr 25000 with data 0x12345678, then read addr 25000 -> mem_write stays 0; the read returns 0x00000000 with readdatavalid; err_oor = 1 and stays set until reset.
- p0 read accepted, reset asserted the next cycle for 2 cycles -> no p0_readdatavalid. After reset: err_oor = 0, O = 0, and the first contended grant goes to p0.
- p1 alone issues 300 consecutive reads, then p0 requests -> C saturates at 255; p0 is granted on the first cycle both request.
